regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single register-file write port between the processor writeback path and up to N_REQ external requesters, such as the button controller and the time-of-day counter. Each external request is buffered in a per-requester one-entry slot. A small state machine stalls the CPU, performs the buffered writes in round-robin order, then releases the CPU. The block sits between the processor's `ctrl_writeEnable`/`ctrl_writeReg`/`data_writeReg` outputs and the regfile write inputs, and drives the processor's `cpuStall` input.

## Interface
- N_REQ, 2, number of external requesters (1..4)
- MAX_BURST, 4, maximum consecutive external writes before the CPU must get one unstalled cycle
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- cpu_we  in  1  CPU writeback enable
- cpu_rd  in  5  CPU destination register
- cpu_data  in  32  CPU writeback data
- req_valid  in  N_REQ  per-requester write request, one bit per requester
- req_reg  in  5*N_REQ  target register; requester i uses bits [5i+4:5i]
- req_data  in  32*N_REQ  write data; requester i uses bits [32i+31:32i]
- req_ready  out  N_REQ  slot i is empty; a request is accepted on req_valid[i] & req_ready[i]
- cpu_stall  out  1  freeze request to the processor
- rf_we  out  1  regfile write enable
- rf_rd  out  5  regfile write address
- rf_data  out  32  regfile write data

## Operation
- **Slots.** Each requester has a slot of {full, reg, data}.
  - Accept: on req_valid[i] & req_ready[i], the slot loads reg/data and sets full.
  - Refused requests are not buffered; the requester holds them until accepted.
- **States.** Registered state machine with states IDLE, STALL and WRITE.
- **IDLE.**
  - cpu_stall=0; rf_* passes cpu_we/cpu_rd/cpu_data through.
  - If any slot is full, go to STALL. The burst counter is cleared.
- **STALL.**
  - cpu_stall=1; rf_we=0. This cycle lets the CPU pipeline freeze.
  - Choose the grant: the first full slot at or after rr_ptr, in circular order.
  - Go to WRITE.
- **WRITE.**
  - cpu_stall=1; rf_rd/rf_data come from the granted slot.
  - rf_we=1 unless the slot's reg is 0; a request to r0 is consumed with no write.
  - The granted slot is cleared at the end of the cycle.
  - rr_ptr becomes grant+1, modulo N_REQ. The burst counter increments.
- **Leaving WRITE.**
  - If another slot is full and burst_cnt+1 < MAX_BURST, stay in WRITE with a new grant computed the same way.
  - Otherwise go to IDLE. This guarantees at least one unstalled CPU cycle after every MAX_BURST external writes.
- **CPU writes while stalled.** While cpu_stall=1, cpu_we is ignored. The processor contract is that no writeback retires while cpu_stall=1.
- **No collisions.** CPU and external writes never share a cycle, so no same-register collision handling is needed.
- **Reset values.** State=IDLE, all slots empty (req_ready all 1), rr_ptr=0, burst_cnt=0, cpu_stall=0.
  - rf_we reflects cpu_we, since IDLE is combinational pass-through.

## Timing
- **Acceptance.** Cycle t: req_valid & req_ready. At t+1 the slot is full and req_ready[i]=0.
- **External write latency.**
  - t+1: IDLE, detects the full slot.
  - t+2: STALL, cpu_stall=1.
  - t+3: WRITE, rf_we=1.
  - t+4: req_ready[i]=1 and, if no other slot is pending, cpu_stall=0.
- **Back-to-back bursts.** Writes from different slots land on consecutive cycles; cpu_stall stays high throughout.
- **Refill during WRITE.** A slot cleared in WRITE cannot refill in the same cycle. Its requester can be accepted the next cycle at the earliest, which prevents a single requester from starving the others.
- **Simultaneous acceptance.** Acceptance on several slots in one cycle is legal; they are drained in round-robin order starting at rr_ptr.
- **Reset mid-operation.** Synchronous reset in STALL or WRITE:
  - Next cycle is IDLE with cpu_stall=0 and all slots empty.
  - Buffered requests are discarded, and no rf_we from a slot is issued in the reset cycle.
- **Output timing.** cpu_stall is a function of registered state only (no combinational path from inputs). rf_* is combinational from state, slots and cpu_* inputs.

## Test plan
- **Reset.** Assert reset for 2 cycles with req_valid=2'b11.
  - Expect cpu_stall=0 and req_ready=2'b11 after release.
  - With cpu_we=1, cpu_rd=5, cpu_data=0x1234: expect rf_we=1, rf_rd=5, rf_data=0x1234.
- **Single request.** req_valid[0] pulse at t with reg=7, data=0xA5.
  - Expect cpu_stall=1 at t+2..t+3.
  - Expect rf_we=1, rf_rd=7, rf_data=0xA5 exactly at t+3; cpu_stall=0 and req_ready[0]=1 at t+4.
  - A cpu_we asserted at t+2 must not reach rf_we.
- **Simultaneous requests.** Both requesters valid in one cycle (reg 3/0x11 and reg 4/0x22), rr_ptr=0.
  - Expect writes r3 then r4 on consecutive cycles.
  - Repeat with rr_ptr=1; expect r4 first.
- **Burst limit.** N_REQ=4, MAX_BURST=2, all four slots full.
  - Expect 2 writes, 1 IDLE cycle with cpu_stall=0, then STALL and the remaining 2 writes.
- **Write to r0.** Request to r0 with data 0xFF.
  - Expect a STALL/WRITE sequence with rf_we=0 throughout, and the slot freed (req_ready=1 after).
- **Reset mid-operation.** Assert reset in the STALL cycle of a pending request.
  - Expect no rf_we from the slot, cpu_stall=0 the next cycle, and req_ready all 1.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle between the CPU writeback path, external requesters and the
// register-file write port for regfile_write_arbiter.
interface regfile_write_arbiter_if #(
  parameter int N_REQ = 2
);
  logic                        cpu_we;
  logic [4:0]                  cpu_rd;
  logic [31:0]                 cpu_data;
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0][4:0]       req_reg;
  logic [N_REQ-1:0][31:0]      req_data;
  logic [N_REQ-1:0]            req_ready;
  logic                        cpu_stall;
  logic                        rf_we;
  logic [4:0]                  rf_rd;
  logic [31:0]                 rf_data;

  modport master (
    output cpu_we, cpu_rd, cpu_data, req_valid, req_reg, req_data,
    input  req_ready, cpu_stall, rf_we, rf_rd, rf_data
  );

  modport slave (
    input  cpu_we, cpu_rd, cpu_data, req_valid, req_reg, req_data,
    output req_ready, cpu_stall, rf_we, rf_rd, rf_data
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between CPU writeback and N_REQ buffered
// external requesters; stalls the CPU while draining slots round-robin.
module regfile_write_arbiter_slot (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [4:0]  reg_in,
  input  logic [31:0] data_in,
  output logic        full,
  output logic [4:0]  rd,
  output logic [31:0] data
);
  always_ff @(posedge clock) begin
    if (reset)      full <= 1'b0;
    else if (clear) full <= 1'b0;
    else if (load)  full <= 1'b1;
    if (load) begin
      rd   <= reg_in;
      data <= data_in;
    end
  end
endmodule

module regfile_write_arbiter #(
  parameter int N_REQ     = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, STALL, WRITE} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d, gnt_q, gnt_d;
  logic [BW-1:0]          burst_q, burst_d;
  logic [N_REQ-1:0]       full, load, clear, pending;
  logic [N_REQ-1:0][4:0]  slot_rd;
  logic [N_REQ-1:0][31:0] slot_data;

  // First set bit of m at or after start, in circular order.
  function automatic logic [PW-1:0] pick(input logic [N_REQ-1:0] m,
                                         input logic [PW-1:0]    start);
    logic [PW-1:0] r;
    int idx;
    r = start;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % N_REQ;
      if (m[idx]) r = PW'(idx);
    end
    return r;
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_slot
    assign load[g]  = bus.req_valid[g] & ~full[g];
    assign clear[g] = (state_q == WRITE) && (gnt_q == PW'(g));

    regfile_write_arbiter_slot u_slot (
      .clock   (clock),
      .reset   (reset),
      .load    (load[g]),
      .clear   (clear[g]),
      .reg_in  (bus.req_reg[g]),
      .data_in (bus.req_data[g]),
      .full    (full[g]),
      .rd      (slot_rd[g]),
      .data    (slot_data[g])
    );
  end

  assign bus.req_ready = ~full;
  // Slots still waiting once the current grant retires; new arrivals wait
  // for the next STALL so a freshly drained requester cannot jump the queue.
  assign pending = full & ~clear;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      burst_q  <= burst_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gnt_d         = gnt_q;
    burst_d       = burst_q;
    bus.cpu_stall = 1'b0;
    bus.rf_we     = 1'b0;
    bus.rf_rd     = '0;
    bus.rf_data   = '0;
    case (state_q)
      IDLE: begin
        bus.rf_we   = bus.cpu_we;
        bus.rf_rd   = bus.cpu_rd;
        bus.rf_data = bus.cpu_data;
        burst_d     = '0;
        if (|full) state_d = STALL;
      end
      STALL: begin
        bus.cpu_stall = 1'b1;
        gnt_d         = pick(full, rr_ptr_q);
        state_d       = WRITE;
      end
      WRITE: begin
        bus.cpu_stall = 1'b1;
        bus.rf_rd     = slot_rd[gnt_q];
        bus.rf_data   = slot_data[gnt_q];
        // r0 requests are consumed silently; reset suppresses the slot write.
        bus.rf_we     = (slot_rd[gnt_q] != 5'd0) && !reset;
        rr_ptr_d      = PW'((int'(gnt_q) + 1) % N_REQ);
        burst_d       = burst_q + BW'(1);
        if ((|pending) && (int'(burst_q) + 1 < MAX_BURST))
          gnt_d = pick(pending, rr_ptr_d);
        else
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: two instances (2 requesters and
// 4 requesters with a burst limit of 2), scoreboard checks every slot write.
module tb_regfile_write_arbiter;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  regfile_write_arbiter_if #(.N_REQ(2)) ifa ();
  regfile_write_arbiter_if #(.N_REQ(4)) ifb ();

  regfile_write_arbiter #(.N_REQ(2), .MAX_BURST(4)) dut_a (
    .clock (clock), .reset (reset), .bus (ifa));
  regfile_write_arbiter #(.N_REQ(4), .MAX_BURST(2)) dut_b (
    .clock (clock), .reset (reset), .bus (ifb));

  int n_assert = 0;
  int n_fail   = 0;
  logic [36:0] exp_a[$];
  logic [36:0] exp_b[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Slot writes are the only writes that may occur while the CPU is stalled.
  always @(negedge clock) begin : mon_a
    logic [36:0] e;
    if (reset === 1'b0 && ifa.cpu_stall === 1'b1 && ifa.rf_we === 1'b1) begin
      if (exp_a.size() == 0) chk("a_unexpected_write", ifa.rf_we, 1'b0);
      else begin
        e = exp_a.pop_front();
        chk("a_write", {ifa.rf_rd, ifa.rf_data}, e);
      end
    end
  end

  always @(negedge clock) begin : mon_b
    logic [36:0] e;
    if (reset === 1'b0 && ifb.cpu_stall === 1'b1 && ifb.rf_we === 1'b1) begin
      if (exp_b.size() == 0) chk("b_unexpected_write", ifb.rf_we, 1'b0);
      else begin
        e = exp_b.pop_front();
        chk("b_write", {ifb.rf_rd, ifb.rf_data}, e);
      end
    end
  end

  task automatic pair(input string tag, input bit slot1_first);
    cyc();
    ifa.req_valid = 2'b11;
    ifa.req_reg[0] = 5'd3; ifa.req_data[0] = 32'h11;
    ifa.req_reg[1] = 5'd4; ifa.req_data[1] = 32'h22;
    if (slot1_first) begin
      exp_a.push_back({5'd4, 32'h22}); exp_a.push_back({5'd3, 32'h11});
    end else begin
      exp_a.push_back({5'd3, 32'h11}); exp_a.push_back({5'd4, 32'h22});
    end
    #1 chk({tag, "_ready_t"}, ifa.req_ready, 2'b11);
    cyc(); ifa.req_valid = 2'b00;
    #1 chk({tag, "_ready_t1"}, ifa.req_ready, 2'b00);
    chk({tag, "_stall_t1"}, ifa.cpu_stall, 1'b0);
    cyc(); #1 chk({tag, "_stall_t2"}, ifa.cpu_stall, 1'b1);
    chk({tag, "_we_t2"}, ifa.rf_we, 1'b0);
    cyc(); #1 chk({tag, "_stall_t3"}, ifa.cpu_stall, 1'b1);
    chk({tag, "_rd_t3"}, ifa.rf_rd, slot1_first ? 5'd4 : 5'd3);
    cyc(); #1 chk({tag, "_stall_t4"}, ifa.cpu_stall, 1'b1);
    chk({tag, "_rd_t4"}, ifa.rf_rd, slot1_first ? 5'd3 : 5'd4);
    chk({tag, "_we_t4"}, ifa.rf_we, 1'b1);
    cyc(); #1 chk({tag, "_stall_t5"}, ifa.cpu_stall, 1'b0);
    chk({tag, "_ready_t5"}, ifa.req_ready, 2'b11);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [0:8] st_exp;
    logic [0:8] we_exp;
    reset = 1'b1;
    ifa.cpu_we = 1'b0; ifa.cpu_rd = '0; ifa.cpu_data = '0;
    ifa.req_valid = 2'b11; ifa.req_reg = '0; ifa.req_data = '0;
    ifb.cpu_we = 1'b0; ifb.cpu_rd = '0; ifb.cpu_data = '0;
    ifb.req_valid = '0; ifb.req_reg = '0; ifb.req_data = '0;

    // Reset with requests held, then pass-through.
    cyc(); cyc();
    reset = 1'b0; ifa.req_valid = 2'b00;
    ifa.cpu_we = 1'b1; ifa.cpu_rd = 5'd5; ifa.cpu_data = 32'h1234;
    #1 chk("rst_stall", ifa.cpu_stall, 1'b0);
    chk("rst_ready", ifa.req_ready, 2'b11);
    chk("rst_ready_b", ifb.req_ready, 4'hF);
    chk("pass_we", ifa.rf_we, 1'b1);
    chk("pass_rd", ifa.rf_rd, 5'd5);
    chk("pass_data", ifa.rf_data, 32'h1234);

    // Single request on slot 0; CPU write at t+2 must be dropped.
    cyc(); ifa.cpu_we = 1'b0;
    ifa.req_valid = 2'b01; ifa.req_reg[0] = 5'd7; ifa.req_data[0] = 32'hA5;
    exp_a.push_back({5'd7, 32'hA5});
    cyc(); ifa.req_valid = 2'b00;
    #1 chk("single_ready_t1", ifa.req_ready, 2'b10);
    chk("single_stall_t1", ifa.cpu_stall, 1'b0);
    cyc(); ifa.cpu_we = 1'b1; ifa.cpu_rd = 5'd9; ifa.cpu_data = 32'hDEAD;
    #1 chk("single_stall_t2", ifa.cpu_stall, 1'b1);
    chk("single_cpu_we_blocked", ifa.rf_we, 1'b0);
    cyc(); ifa.cpu_we = 1'b0;
    #1 chk("single_stall_t3", ifa.cpu_stall, 1'b1);
    chk("single_we_t3", ifa.rf_we, 1'b1);
    chk("single_rd_t3", ifa.rf_rd, 5'd7);
    chk("single_data_t3", ifa.rf_data, 32'hA5);
    cyc(); #1 chk("single_stall_t4", ifa.cpu_stall, 1'b0);
    chk("single_ready_t4", ifa.req_ready, 2'b11);

    // rr_ptr is now 1: slot 1 drains first.
    pair("pair_rr1", 1'b1);

    // r0 request on slot 1: consumed with no write, rr_ptr returns to 0.
    cyc(); ifa.req_valid = 2'b10; ifa.req_reg[1] = 5'd0; ifa.req_data[1] = 32'hFF;
    cyc(); ifa.req_valid = 2'b00;
    #1 chk("r0_ready_t1", ifa.req_ready, 2'b01);
    cyc(); #1 chk("r0_stall_t2", ifa.cpu_stall, 1'b1);
    chk("r0_we_t2", ifa.rf_we, 1'b0);
    cyc(); #1 chk("r0_stall_t3", ifa.cpu_stall, 1'b1);
    chk("r0_we_t3", ifa.rf_we, 1'b0);
    cyc(); #1 chk("r0_stall_t4", ifa.cpu_stall, 1'b0);
    chk("r0_ready_t4", ifa.req_ready, 2'b11);

    pair("pair_rr0", 1'b0);

    // Reset during STALL discards the buffered request.
    cyc(); ifa.req_valid = 2'b01; ifa.req_reg[0] = 5'd12; ifa.req_data[0] = 32'h77;
    cyc(); ifa.req_valid = 2'b00;
    cyc(); reset = 1'b1;
    #1 chk("rstmid_stall_t2", ifa.cpu_stall, 1'b1);
    chk("rstmid_we_t2", ifa.rf_we, 1'b0);
    cyc(); reset = 1'b0;
    #1 chk("rstmid_stall_t3", ifa.cpu_stall, 1'b0);
    chk("rstmid_ready_t3", ifa.req_ready, 2'b11);
    chk("rstmid_we_t3", ifa.rf_we, 1'b0);
    cyc(); #1 chk("rstmid_stall_t4", ifa.cpu_stall, 1'b0);
    chk("rstmid_we_t4", ifa.rf_we, 1'b0);

    // Burst limit 2 with four full slots: two writes, one free cycle, two writes.
    cyc(); ifb.req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      ifb.req_reg[i]  = 5'(20 + i);
      ifb.req_data[i] = 32'h100 + 32'(i);
      exp_b.push_back({5'(20 + i), 32'h100 + 32'(i)});
    end
    st_exp = 9'b011101110;
    we_exp = 9'b001100110;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      if (i == 1) ifb.req_valid = 4'h0;
      #1 chk($sformatf("burst_stall_t%0d", i), ifb.cpu_stall, st_exp[i-1]);
      chk($sformatf("burst_we_t%0d", i), ifb.rf_we, we_exp[i-1]);
      if (i == 5) chk("burst_ready_gap", ifb.req_ready, 4'b0011);
    end
    chk("burst_ready_end", ifb.req_ready, 4'hF);

    cyc();
    chk("a_queue_drained", exp_a.size(), 0);
    chk("b_queue_drained", exp_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
